// File: rtl/wtm_dot_acc_4bit.sv
// Streaming 4-bit dot-product accumulator around a Wallace tree multiplier.
// Operand reg -> product reg -> accumulator -> held result, one pair/cycle.

module wtm_4bit_20BEE0082 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  function automatic logic [1:0] fa(
    input logic x,
    input logic y,
    input logic z
  );
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] ha(
    input logic x,
    input logic y
  );
    return {x & y, x ^ y};
  endfunction

  // pp[i][j] = a[j] & b[i], weight i+j
  logic [3:0] pp [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = a_i & {4{b_i[i]}};
    end
  end

  logic s11, c11, s12, c12, s13, c13;
  logic s14, c14, s15, c15;
  logic s23, c23, s24, c24;
  logic s25, c25, s26, c26;
  logic [7:0] row_x, row_y;

  assign {c11, s11} = ha(pp[0][1], pp[1][0]);
  assign {c12, s12} = fa(pp[0][2], pp[1][1], pp[2][0]);
  assign {c13, s13} = fa(pp[0][3], pp[1][2], pp[2][1]);
  assign {c14, s14} = fa(pp[1][3], pp[2][2], pp[3][1]);
  assign {c15, s15} = ha(pp[2][3], pp[3][2]);

  assign {c23, s23} = fa(s13, pp[3][0], c12);
  assign {c24, s24} = ha(s14, c13);
  assign {c25, s25} = fa(s15, c14, c24);
  assign {c26, s26} = fa(pp[3][3], c15, c25);

  // two remaining rows go through the final carry-propagate add
  assign row_x = {c26, s26, s25, s24, s23, s12, s11, pp[0][0]};
  assign row_y = {3'b000, c23, 1'b0, c11, 2'b00};
  assign p_o   = row_x + row_y;

endmodule

module wtm_dot_acc_4bit #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

  logic [3:0]       op_a_q, op_a_d;
  logic [3:0]       op_b_q, op_b_d;
  logic             op_v_q, op_v_d;
  logic [7:0]       prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sovf_q, sovf_d;
  logic             ov_q, ov_d;

  logic             en;
  logic             accept;
  logic [7:0]       mul_p;
  logic [ACC_W:0]   sum_ext;

  wtm_4bit_20BEE0082 u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  // a held, unconsumed result freezes the whole pipe
  assign en     = !rst && !(ov_q && !out_ready);
  assign accept = in_valid && en;

  assign in_ready  = en;
  assign out_valid = ov_q;
  assign out_sum   = sum_q;
  assign out_ovf   = sovf_q;
  assign busy      = op_v_q | prod_v_q | (cnt_q != '0);

  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_v_d   = op_v_q;
    prod_d   = prod_q;
    prod_v_d = prod_v_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    sum_d    = sum_q;
    sovf_d   = sovf_q;
    ov_d     = ov_q;
    sum_ext  = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);
    if (en) begin
      op_v_d = accept;
      if (accept) begin
        op_a_d = in_a;
        op_b_d = in_b;
      end
      prod_d   = mul_p;
      prod_v_d = op_v_q;
      ov_d     = 1'b0;
      if (prod_v_q) begin
        if (cnt_q == LAST) begin
          sum_d  = sum_ext[ACC_W-1:0];
          sovf_d = ovf_q | sum_ext[ACC_W];
          ov_d   = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
        end else begin
          acc_d = sum_ext[ACC_W-1:0];
          cnt_d = cnt_q + CW'(1);
          ovf_d = ovf_q | sum_ext[ACC_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_v_q   <= 1'b0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sum_q    <= '0;
      sovf_q   <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_v_q   <= op_v_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sum_q    <= sum_d;
      sovf_q   <= sovf_d;
      ov_q     <= ov_d;
    end
  end

endmodule
